// File: rtl/traffic_pkg.sv
// traffic_pkg: phase codes, scheduler states and direction constants shared by the scheduler
package traffic_pkg;
    typedef enum logic [1:0] {PH_NS_GO = 2'd0, PH_EW_GO = 2'd1, PH_ALL_RED = 2'd2} phase_t;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_RUN = 2'd2} sched_state_t;
    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;
    function automatic logic [1:0] go_phase(input logic dir);
        return dir == DIR_NS ? PH_NS_GO : PH_EW_GO;
    endfunction
endpackage

// File: rtl/ped_request_latch.sv
// ped_request_latch: holds a pedestrian request from its set pulse until cleared, set winning ties
module ped_request_latch (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic pending
);
    always_ff @(posedge clk) pending <= reset ? 1'b0 : set | (pending & ~clr);
endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: arbitrates NS/EW/pedestrian/emergency green and issues phase commands
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_SECS = 5,
    parameter int WALK_SECS  = 8,
    parameter int CLEAR_SECS = 1,
    parameter int EMERG_SECS = 4,
    parameter int SECS_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              ped_ns_req,
    input  logic              ped_ew_req,
    input  logic              emerg_req,
    input  logic              emerg_dir,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    output logic              cmd_valid,
    output logic [1:0]        cmd_phase,
    output logic [SECS_W-1:0] cmd_secs,
    output logic              cmd_walk,
    output logic              cmd_abort,
    output logic [1:0]        state_o
);
    sched_state_t      state;
    logic              last_go, cmd_emerg, abort_sent, pend_ns, pend_ew;
    logic              xfer, go_active, go_dir, rot_dir, rot_ped, extend, nxt_emerg, nxt_walk;
    logic [1:0]        nxt_phase;
    logic [SECS_W-1:0] nxt_secs;
    assign state_o   = state;
    assign xfer      = state == ST_ISSUE && cmd_valid && cmd_ready;
    assign go_active = cmd_phase != PH_ALL_RED;
    assign go_dir    = cmd_phase[0];
    assign rot_dir   = ~last_go;
    assign rot_ped   = rot_dir == DIR_EW ? pend_ew : pend_ns;
    assign extend    = cmd_emerg && emerg_req && emerg_dir == go_dir;
    assign nxt_emerg = extend || (!go_active && emerg_req);
    assign nxt_walk  = !go_active && !emerg_req && rot_ped;
    assign nxt_phase = extend ? cmd_phase : go_active ? PH_ALL_RED : go_phase(emerg_req ? emerg_dir : rot_dir);
    assign nxt_secs  = nxt_emerg ? SECS_W'(EMERG_SECS) : go_active ? SECS_W'(CLEAR_SECS)
                     : rot_ped ? SECS_W'(WALK_SECS) : SECS_W'(GREEN_SECS);
    ped_request_latch u_ped_ns (
        .clk(clk), .reset(reset || !enable), .set(ped_ns_req),
        .clr(xfer && cmd_walk && cmd_phase == PH_NS_GO), .pending(pend_ns)
    );
    ped_request_latch u_ped_ew (
        .clk(clk), .reset(reset || !enable), .set(ped_ew_req),
        .clr(xfer && cmd_walk && cmd_phase == PH_EW_GO), .pending(pend_ew)
    );
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state      <= ST_IDLE;
            cmd_valid  <= 1'b0;
            cmd_abort  <= 1'b0;
            last_go    <= DIR_EW;
            cmd_emerg  <= 1'b0;
            abort_sent <= 1'b0;
            if (reset) begin
                cmd_phase <= PH_ALL_RED;
                cmd_secs  <= '0;
                cmd_walk  <= 1'b0;
            end
        end else begin
            cmd_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state     <= ST_ISSUE;
                    cmd_phase <= PH_ALL_RED;
                    cmd_secs  <= SECS_W'(CLEAR_SECS);
                    cmd_walk  <= 1'b0;
                    cmd_emerg <= 1'b0;
                end
                ST_ISSUE: begin
                    if (!cmd_valid) cmd_valid <= 1'b1;
                    else if (cmd_ready) begin
                        state     <= ST_RUN;
                        cmd_valid <= 1'b0;
                        if (go_active) last_go <= go_dir;
                    end
                end
                ST_RUN: begin
                    if (cmd_done) begin
                        state      <= ST_ISSUE;
                        cmd_valid  <= 1'b1;
                        cmd_phase  <= nxt_phase;
                        cmd_secs   <= nxt_secs;
                        cmd_walk   <= nxt_walk;
                        cmd_emerg  <= nxt_emerg;
                        abort_sent <= 1'b0;
                    end else if (go_active && go_dir != emerg_dir && emerg_req && !abort_sent) begin
                        cmd_abort  <= 1'b1;
                        abort_sent <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: directed stimulus with a queue scoreboard checked at every command handshake
module tb_intersection_phase_scheduler;
    typedef struct packed {logic [1:0] ph; logic [3:0] secs; logic walk;} cmd_t;
    logic       clk = 1'b0;
    logic       reset, enable, ped_ns_req, ped_ew_req, emerg_req, emerg_dir, cmd_ready, cmd_done;
    logic       cmd_valid, cmd_walk, cmd_abort;
    logic [1:0] cmd_phase, state_o;
    logic [3:0] cmd_secs;
    cmd_t       exp_q[$];
    cmd_t       got, want, prev_cmd;
    logic       prev_hold = 1'b0, prev_en = 1'b0;
    int         n_checks = 0, n_fail = 0, done_cnt = 0, done_budget = 0, abort_cnt = 0, abort_base;

    intersection_phase_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable), .ped_ns_req(ped_ns_req), .ped_ew_req(ped_ew_req),
        .emerg_req(emerg_req), .emerg_dir(emerg_dir), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
        .cmd_valid(cmd_valid), .cmd_phase(cmd_phase), .cmd_secs(cmd_secs), .cmd_walk(cmd_walk),
        .cmd_abort(cmd_abort), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int ph, input int secs, input int walk);
        exp_q.push_back(cmd_t'{ph: 2'(ph), secs: 4'(secs), walk: 1'(walk)});
    endtask

    task automatic req_done();
        @(negedge clk);
        #1;
        done_cnt = 1;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, " drained"}, exp_q.size(), 0);
    endtask

    // Datapath model: counts down to a one-cycle done pulse
    initial forever begin
        tick();
        cmd_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) cmd_done = 1'b1;
        end
    end

    // Monitor: scoreboard pop at handshake, valid/field hold while stalled, abort pulse count
    initial forever begin
        @(negedge clk);
        got = {cmd_phase, cmd_secs, cmd_walk};
        if (prev_hold && prev_en) begin
            n_checks++;
            if (!cmd_valid || got != prev_cmd) begin
                n_fail++;
                $display("FAIL hold: got valid=%0d cmd=%0d/%0d/%0d, expected valid=1 cmd=%0d/%0d/%0d",
                         cmd_valid, got.ph, got.secs, got.walk, prev_cmd.ph, prev_cmd.secs, prev_cmd.walk);
            end
        end
        if (cmd_abort) abort_cnt++;
        if (cmd_valid && cmd_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cmd: got unexpected %0d/%0d/%0d, expected none", got.ph, got.secs, got.walk);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    n_fail++;
                    $display("FAIL cmd: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                             got.ph, got.secs, got.walk, want.ph, want.secs, want.walk);
                end
            end
            if (done_budget > 0) begin
                done_budget--;
                done_cnt = 3;
            end
        end
        prev_hold = cmd_valid && !cmd_ready;
        prev_cmd  = got;
        prev_en   = enable;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; ped_ns_req = 1'b0; ped_ew_req = 1'b0;
        emerg_req = 1'b0; emerg_dir = 1'b0; cmd_ready = 1'b1; cmd_done = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset state", state_o, 0);
        check("reset valid", cmd_valid, 0);
        check("reset phase", cmd_phase, 2);
        check("reset secs", cmd_secs, 0);
        check("reset walk", cmd_walk, 0);
        check("reset abort", cmd_abort, 0);

        // Basic rotation
        push(2, 1, 0); push(0, 5, 0); push(2, 1, 0); push(1, 5, 0); push(2, 1, 0); push(0, 5, 0);
        done_budget = 5;
        enable = 1'b1;
        tick();
        check("enable latency 1 state", state_o, 1);
        check("enable latency 1 valid", cmd_valid, 0);
        tick();
        check("enable latency 2 valid", cmd_valid, 1);
        wait_empty("rotation");

        // EW pedestrian request during NS green
        tick();
        ped_ew_req = 1'b1;
        tick();
        ped_ew_req = 1'b0;
        push(2, 1, 0); push(1, 8, 1); push(2, 1, 0); push(0, 5, 0); push(2, 1, 0); push(1, 5, 0);
        done_budget = 5;
        req_done();
        wait_empty("ped ew");

        // Stall in ISSUE
        tick();
        cmd_ready = 1'b0;
        push(2, 1, 0);
        req_done();
        repeat (10) tick();
        check("stall valid", cmd_valid, 1);
        check("stall phase", cmd_phase, 2);
        check("stall secs", cmd_secs, 1);
        check("stall state", state_o, 1);
        cmd_ready = 1'b1;
        tick();
        check("post transfer valid", cmd_valid, 0);
        check("post transfer state", state_o, 2);
        wait_empty("stall");

        // Emergency preempt of EW green
        push(0, 5, 0); push(2, 1, 0); push(1, 5, 0);
        done_budget = 2;
        req_done();
        wait_empty("to ew");
        tick();
        abort_base = abort_cnt;
        emerg_req = 1'b1;
        emerg_dir = 1'b0;
        repeat (5) tick();
        check("abort pulses", abort_cnt - abort_base, 1);
        check("abort low after pulse", cmd_abort, 0);
        push(2, 1, 0); push(0, 4, 0); push(0, 4, 0);
        done_budget = 2;
        req_done();
        wait_empty("emergency");
        repeat (3) tick();
        check("no abort in emerg dir", abort_cnt - abort_base, 1);
        emerg_req = 1'b0;
        push(2, 1, 0); push(1, 5, 0);
        done_budget = 1;
        req_done();
        wait_empty("emergency release");

        // Disable mid-run with NS pedestrian pending
        tick();
        ped_ns_req = 1'b1;
        tick();
        ped_ns_req = 1'b0;
        enable = 1'b0;
        tick();
        check("disable state", state_o, 0);
        check("disable valid", cmd_valid, 0);
        repeat (3) tick();
        push(2, 1, 0); push(0, 5, 0);
        done_budget = 1;
        enable = 1'b1;
        tick();
        check("reenable latency 1 valid", cmd_valid, 0);
        tick();
        check("reenable latency 2 valid", cmd_valid, 1);
        wait_empty("reenable");

        // NS pedestrian request coinciding with a walk NS_GO handshake
        tick();
        ped_ns_req = 1'b1;
        tick();
        ped_ns_req = 1'b0;
        push(2, 1, 0); push(1, 5, 0); push(2, 1, 0);
        done_budget = 2;
        req_done();
        wait_empty("to ns walk");
        tick();
        cmd_ready = 1'b0;
        push(0, 8, 1);
        req_done();
        repeat (3) tick();
        check("ns walk held", cmd_walk, 1);
        ped_ns_req = 1'b1;
        cmd_ready = 1'b1;
        tick();
        ped_ns_req = 1'b0;
        wait_empty("ns walk");
        push(2, 1, 0); push(1, 5, 0); push(2, 1, 0); push(0, 8, 1);
        done_budget = 3;
        req_done();
        wait_empty("ns walk again");

        repeat (5) tick();
        check("no stray commands", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
